// File: rtl/project_cfg_pkg.sv
// project_cfg_pkg: shared game configuration, board cell codes and controller states
package project_cfg_pkg;
  localparam int SHIPS_NUMBER = 10;
  localparam logic [1:0] GRID_STATUS_EMPTY  = 2'd0;
  localparam logic [1:0] GRID_STATUS_MYSHIP = 2'd1;
  localparam logic [1:0] GRID_STATUS_HIT    = 2'd2;
  localparam logic [1:0] GRID_STATUS_MISS   = 2'd3;
  typedef enum logic [4:0] {
    PLACE_IDLE, PLACE_RD, PLACE_CHK,
    WAIT_ENEMY, RX_RD, RX_CHK, RX_ACK,
    AIM, AIM_RD, AIM_CHK, WAIT_ANSWER,
    WIN, LOSE, TIMEOUT
  } game_state_t;
endpackage

// File: rtl/peer_timeout_ctr.sv
// peer_timeout_ctr: down-counter that flags expiry after CYCLES enabled cycles; CYCLES=0 never expires
module peer_timeout_ctr #(
  parameter int CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = CYCLES > 0 ? $clog2(CYCLES + 1) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  // reload on clear, count down while enabled, hold at zero
  always_comb cnt_d = clr ? W'(CYCLES) : (en && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  // count register
  always_ff @(posedge clk) cnt_q <= rst ? W'(CYCLES) : cnt_d;
  assign expired = (CYCLES != 0) && (cnt_q == '0);
endmodule

// File: rtl/game_ctrl_fsm.sv
// game_ctrl_fsm: ship placement, turn-based shooting and end-of-game control for one peer board
module game_ctrl_fsm
  import project_cfg_pkg::*;
#(
  parameter int CORD_W = 8,
  parameter int SHIPS_NUMBER = project_cfg_pkg::SHIPS_NUMBER,
  parameter int TIMEOUT_CYCLES = 65_000_000,
  localparam int CTR_W = $clog2(SHIPS_NUMBER + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_btn,
  output logic              start_btn_en,
  input  logic [CORD_W-1:0] my_grid_cords,
  input  logic [CORD_W-1:0] en_grid_cords,
  output logic [CORD_W-1:0] my_mem_addr,
  output logic [1:0]        my_mem_data_out,
  output logic              my_mem_w_nr,
  input  logic [1:0]        my_mem_data_in,
  output logic [CORD_W-1:0] en_mem_addr,
  output logic [1:0]        en_mem_data_out,
  output logic              en_mem_w_nr,
  input  logic [1:0]        en_mem_data_in,
  input  logic              ready2,
  input  logic              hit2,
  input  logic [CORD_W-1:0] ship_cords_in,
  output logic              ready1,
  output logic              hit1,
  output logic [CORD_W-1:0] ship_cords_out,
  output logic [CTR_W-1:0]  my_ctr,
  output logic [CTR_W-1:0]  en_ctr,
  output logic [4:0]        state_out,
  output logic              win,
  output logic              lose,
  output logic              timeout,
  output logic              my_turn,
  output logic              en_turn
);
  localparam logic [CORD_W-1:0] NONE = '1;
  localparam logic [CTR_W-1:0] FULL = CTR_W'(SHIPS_NUMBER);

  game_state_t state_q, state_d;
  logic [CORD_W-1:0] my_mem_addr_q, my_mem_addr_d, en_mem_addr_q, en_mem_addr_d;
  logic [CORD_W-1:0] ship_cords_out_q, ship_cords_out_d;
  logic [1:0] my_mem_data_out_q, my_mem_data_out_d, en_mem_data_out_q, en_mem_data_out_d;
  logic my_mem_w_nr_q, my_mem_w_nr_d, en_mem_w_nr_q, en_mem_w_nr_d;
  logic [CTR_W-1:0] my_ctr_q, my_ctr_d, en_ctr_q, en_ctr_d;
  logic ready1_q, ready1_d, hit1_q, hit1_d, start_btn_en_q, start_btn_en_d;
  logic win_q, win_d, lose_q, lose_d, timeout_q, timeout_d;
  logic my_turn_q, my_turn_d, en_turn_q, en_turn_d;
  logic click_armed_q, click_armed_d, ready2_q;
  logic waiting, expired;

  function automatic logic [CTR_W-1:0] dec_sat(input logic [CTR_W-1:0] v);
    return v == '0 ? v : v - CTR_W'(1);
  endfunction

  assign waiting = (state_q == RX_ACK) || (state_q == WAIT_ANSWER);

  peer_timeout_ctr #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (!waiting),
    .en      (waiting),
    .expired (expired)
  );

  // next state, memory requests, counters and status flags
  always_comb begin
    state_d = state_q;
    my_mem_addr_d = my_mem_addr_q;
    en_mem_addr_d = en_mem_addr_q;
    ship_cords_out_d = ship_cords_out_q;
    my_mem_data_out_d = my_mem_data_out_q;
    en_mem_data_out_d = en_mem_data_out_q;
    my_mem_w_nr_d = 1'b0;
    en_mem_w_nr_d = 1'b0;
    my_ctr_d = my_ctr_q;
    en_ctr_d = en_ctr_q;
    ready1_d = ready1_q;
    hit1_d = hit1_q;
    start_btn_en_d = start_btn_en_q;
    click_armed_d = (my_grid_cords == NONE && en_grid_cords == NONE) ? 1'b1 : click_armed_q;
    unique case (state_q)
      PLACE_IDLE:
        if (start_btn && my_ctr_q == '0) begin
          my_ctr_d = FULL;
          en_ctr_d = FULL;
          start_btn_en_d = 1'b0;
          ready1_d = 1'b1;
          state_d = ready2 ? WAIT_ENEMY : AIM;
        end else if (my_grid_cords != NONE && my_ctr_q != '0 && click_armed_q) begin
          my_mem_addr_d = my_grid_cords;
          click_armed_d = 1'b0;
          state_d = PLACE_RD;
        end
      PLACE_RD: state_d = PLACE_CHK;
      PLACE_CHK: begin
        if (my_mem_data_in == GRID_STATUS_EMPTY) begin
          my_mem_w_nr_d = 1'b1;
          my_mem_data_out_d = GRID_STATUS_MYSHIP;
          my_ctr_d = dec_sat(my_ctr_q);
        end
        state_d = PLACE_IDLE;
      end
      WAIT_ENEMY:
        if (my_ctr_q == '0) state_d = LOSE;
        else if (en_ctr_q == '0) state_d = WIN;
        else if (hit2 && ready2) begin
          my_mem_addr_d = ship_cords_in;
          ready1_d = 1'b0;
          state_d = RX_RD;
        end
      RX_RD: state_d = RX_CHK;
      RX_CHK: begin
        hit1_d = my_mem_data_in == GRID_STATUS_MYSHIP;
        if (my_mem_data_in == GRID_STATUS_MYSHIP) begin
          my_mem_w_nr_d = 1'b1;
          my_mem_data_out_d = GRID_STATUS_HIT;
          my_ctr_d = dec_sat(my_ctr_q);
        end else if (my_mem_data_in == GRID_STATUS_EMPTY) begin
          my_mem_w_nr_d = 1'b1;
          my_mem_data_out_d = GRID_STATUS_MISS;
        end
        ready1_d = 1'b1;
        state_d = RX_ACK;
      end
      RX_ACK:
        if (expired) begin
          ready1_d = 1'b0;
          state_d = TIMEOUT;
        end else if (ready2 && !hit2) begin
          hit1_d = 1'b0;
          state_d = AIM;
        end
      AIM:
        if (my_ctr_q == '0) state_d = LOSE;
        else if (en_ctr_q == '0) state_d = WIN;
        else if (en_grid_cords != NONE && click_armed_q) begin
          en_mem_addr_d = en_grid_cords;
          click_armed_d = 1'b0;
          state_d = AIM_RD;
        end
      AIM_RD: state_d = AIM_CHK;
      AIM_CHK:
        if (en_mem_data_in == GRID_STATUS_EMPTY) begin
          ship_cords_out_d = en_mem_addr_q;
          hit1_d = 1'b1;
          ready1_d = 1'b1;
          state_d = WAIT_ANSWER;
        end else state_d = AIM;
      WAIT_ANSWER: begin
        hit1_d = 1'b0;
        if (expired) begin
          ready1_d = 1'b0;
          state_d = TIMEOUT;
        end else if (ready2 && !ready2_q) begin
          en_mem_w_nr_d = 1'b1;
          en_mem_data_out_d = hit2 ? GRID_STATUS_HIT : GRID_STATUS_MISS;
          en_ctr_d = hit2 ? dec_sat(en_ctr_q) : en_ctr_q;
          state_d = WAIT_ENEMY;
        end
      end
      WIN, LOSE, TIMEOUT:
        if (start_btn) begin
          ready1_d = 1'b0;
          hit1_d = 1'b0;
          my_ctr_d = FULL;
          en_ctr_d = FULL;
          state_d = PLACE_IDLE;
        end
      default: state_d = PLACE_IDLE;
    endcase
    start_btn_en_d = (state_d inside {WIN, LOSE, TIMEOUT}) ? 1'b1 : start_btn_en_d;
    win_d = state_d == WIN;
    lose_d = state_d == LOSE;
    timeout_d = state_d == TIMEOUT;
    my_turn_d = state_d == AIM;
    en_turn_d = state_d == WAIT_ENEMY;
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PLACE_IDLE;
      my_mem_addr_q <= '0;
      en_mem_addr_q <= '0;
      ship_cords_out_q <= '0;
      my_mem_data_out_q <= '0;
      en_mem_data_out_q <= '0;
      my_mem_w_nr_q <= 1'b0;
      en_mem_w_nr_q <= 1'b0;
      my_ctr_q <= FULL;
      en_ctr_q <= FULL;
      ready1_q <= 1'b0;
      hit1_q <= 1'b0;
      start_btn_en_q <= 1'b1;
      win_q <= 1'b0;
      lose_q <= 1'b0;
      timeout_q <= 1'b0;
      my_turn_q <= 1'b0;
      en_turn_q <= 1'b0;
      click_armed_q <= 1'b1;
      ready2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      my_mem_addr_q <= my_mem_addr_d;
      en_mem_addr_q <= en_mem_addr_d;
      ship_cords_out_q <= ship_cords_out_d;
      my_mem_data_out_q <= my_mem_data_out_d;
      en_mem_data_out_q <= en_mem_data_out_d;
      my_mem_w_nr_q <= my_mem_w_nr_d;
      en_mem_w_nr_q <= en_mem_w_nr_d;
      my_ctr_q <= my_ctr_d;
      en_ctr_q <= en_ctr_d;
      ready1_q <= ready1_d;
      hit1_q <= hit1_d;
      start_btn_en_q <= start_btn_en_d;
      win_q <= win_d;
      lose_q <= lose_d;
      timeout_q <= timeout_d;
      my_turn_q <= my_turn_d;
      en_turn_q <= en_turn_d;
      click_armed_q <= click_armed_d;
      ready2_q <= ready2;
    end
  end

  assign start_btn_en = start_btn_en_q;
  assign my_mem_addr = my_mem_addr_q;
  assign my_mem_data_out = my_mem_data_out_q;
  assign my_mem_w_nr = my_mem_w_nr_q;
  assign en_mem_addr = en_mem_addr_q;
  assign en_mem_data_out = en_mem_data_out_q;
  assign en_mem_w_nr = en_mem_w_nr_q;
  assign ready1 = ready1_q;
  assign hit1 = hit1_q;
  assign ship_cords_out = ship_cords_out_q;
  assign my_ctr = my_ctr_q;
  assign en_ctr = en_ctr_q;
  assign state_out = state_q;
  assign win = win_q;
  assign lose = lose_q;
  assign timeout = timeout_q;
  assign my_turn = my_turn_q;
  assign en_turn = en_turn_q;
endmodule

// File: doc/game_ctrl_fsm.md
Name: game_ctrl_fsm

Overview:
Parametrised successor of the main game controller for FPGA_WARSHIPS. It sequences ship placement, turn-based shooting and win/lose detection against one peer board over the ready/hit/cords link. It adds these features over the first generation: configurable grid and fleet size, rejection of duplicate placements and shots via read-before-write, a peer-response timeout, and restart from WIN/LOSE/TIMEOUT. It sits between the mouse/grid decoders, the two board memories (own, enemy) and the inter-board link.

Parameters:
CORD_W, 8, coordinate/memory address width; all-ones value = "no cell selected"
SHIPS_NUMBER, 10, ship cells per player; counters are $clog2(SHIPS_NUMBER+1) bits wide (CTR_W)
TIMEOUT_CYCLES, 65_000_000, max cycles waiting for peer response; 0 disables timeout

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start_btn  in  1  start/restart request (pre-debounced, level)
start_btn_en  out  1  start button enable for UI
my_grid_cords  in  CORD_W  own-grid click cords, all-ones = none
en_grid_cords  in  CORD_W  enemy-grid click cords, all-ones = none
my_mem_addr / my_mem_data_out / my_mem_w_nr  out  CORD_W/2/1  own board memory port
my_mem_data_in  in  2  own board read data, 1-cycle latency
en_mem_addr / en_mem_data_out / en_mem_w_nr  out  CORD_W/2/1  enemy board memory port
en_mem_data_in  in  2  enemy board read data, 1-cycle latency
ready2, hit2  in  1,1  peer ready / peer hit-or-shot flag
ship_cords_in  in  CORD_W  peer shot cords
ready1, hit1  out  1,1  own ready / hit-or-shot flag
ship_cords_out  out  CORD_W  own shot cords
my_ctr, en_ctr  out  CTR_W  remaining own / enemy ship cells
state_out  out  5  current state code
win, lose, timeout, my_turn, en_turn  out  1  status flags

Behaviour:
- Clocking: clk only. Reset is synchronous, active-high. All outputs are registered.
- Reset values:
  - my_ctr = en_ctr = SHIPS_NUMBER.
  - start_btn_en = 1.
  - All other outputs = 0.
  - state = PLACE_IDLE.
- Grid codes come from package: EMPTY=0, MYSHIP=1, HIT=2, MISS=3.
- Placement:
  - PLACE_IDLE: cords != all-ones and my_ctr != 0 -> latch addr, w_nr=0 -> PLACE_RD -> PLACE_CHK.
  - PLACE_CHK: data == EMPTY -> write MYSHIP (w_nr=1 for exactly one cycle), my_ctr-1. Otherwise write nothing and leave the counter unchanged.
  - PLACE_CHK returns to PLACE_IDLE. The next click is accepted only after cords return to all-ones (edge-qualified via a click_armed register).
  - start_btn with my_ctr == 0 -> reload both counters, start_btn_en=0, ready1=1. Then go to WAIT_ENEMY if ready2 else AIM. start_btn with my_ctr != 0 is ignored.
- Defence:
  - WAIT_ENEMY: en_turn=1. hit2 && ready2 -> read own mem at ship_cords_in, ready1=0 -> RX_RD -> RX_CHK.
  - RX_CHK: MYSHIP -> write HIT, hit1=1, my_ctr-1. HIT or MISS (repeat shot) -> no write, hit1=0, counter unchanged. EMPTY -> write MISS, hit1=0. Then ready1=1 -> RX_ACK.
  - RX_ACK: waits for ready2 && !hit2, then clears hit1 -> AIM.
- Attack:
  - AIM: my_turn=1. en_grid_cords != all-ones and click_armed -> read enemy mem -> AIM_RD -> AIM_CHK.
  - AIM_CHK: EMPTY -> ship_cords_out=cords, hit1=1, ready1=1 -> WAIT_ANSWER. HIT/MISS (already shot) -> back to AIM with no shot sent.
- Answer:
  - WAIT_ANSWER: first cycle, drop hit1. Wait for ready2 rising edge.
  - On that edge: write enemy mem HIT if hit2 else MISS (one cycle), en_ctr-1 on hit -> WAIT_ENEMY.
- End of game and timeout:
  - A counter reaching 0 is checked every cycle in WAIT_ENEMY/AIM. my_ctr==0 -> LOSE (lose=1). en_ctr==0 -> WIN (win=1). If both are 0, LOSE wins priority.
  - Timeout counter runs in RX_ACK and WAIT_ANSWER and clears on state entry. Reaching TIMEOUT_CYCLES -> TIMEOUT state, timeout=1, ready1=0.
  - WIN/LOSE/TIMEOUT set start_btn_en=1. start_btn there -> PLACE_IDLE with flags cleared and counters reloaded. Board memories are not cleared; clearing is the top level's responsibility.
- Counters saturate at 0 and never wrap.
- Memory write enables are single-cycle pulses.
- rst mid-game aborts immediately to reset values.

Decomposition:
- Shared package project_cfg_pkg holds SHIPS_NUMBER, the GRID_STATUS_* codes and the state enum typedef game_state_t.
- Sub-module peer_timeout_ctr: parametrised down-counter with clear/enable/expired.

Test Plan:
- Place at 0x00 and 0x00 again -> one MYSHIP write, my_ctr = SHIPS_NUMBER-1, second click produces no write.
- Place all ships, start_btn with ready2=0 -> AIM, my_turn=1, start_btn_en=0. Start with ready2=1 -> WAIT_ENEMY.
- Aim 0x23, en mem reads EMPTY -> ship_cords_out=0x23 with hit1=1 pulse. Peer ready2 edge with hit2=1 -> en mem writes HIT at 0x23, en_ctr decrements.
- Peer shot 0x11 on MYSHIP -> own write HIT, hit1=1, my_ctr-1. Repeat 0x11 -> no write, hit1=0.
- With TIMEOUT_CYCLES=16 and peer silent in WAIT_ANSWER -> timeout=1 after 16 cycles. start_btn -> PLACE_IDLE.
- en_ctr reaches 0 -> win=1 next cycle. rst during WAIT_ANSWER -> all outputs at reset values.
